// File: rtl/radix4_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radix4_div_pkg
// Description : Widths and the stage-register record shared by the divider.
// Revision    : 1.0 - initial release
// ============================================================================
package radix4_div_pkg;

    localparam int DVD_W  = 16;
    localparam int DVS_W  = 8;
    localparam int QUO_W  = 8;
    localparam int STAGES = 4;

    // dvd_lo keeps the whole low dividend byte so a divide-by-zero result can return it.
    typedef struct packed {
        logic               valid;
        logic [DVS_W-1:0]   rem;
        logic [DVD_W-DVS_W-1:0] dvd_lo;
        logic [DVS_W-1:0]   dvs;
        logic [QUO_W-1:0]   quo;
        logic               dz;
        logic               ovf;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/radix4_div_stage.sv
`default_nettype none
// ============================================================================
// Module      : radix4_div_stage
// Description : One radix-4 restoring digit step (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module radix4_div_stage
    import radix4_div_pkg::*;
(
    input  logic [DVS_W-1:0] i_rem,
    input  logic [1:0]       i_pair,
    input  logic [DVS_W-1:0] i_dvs,
    output logic [1:0]       o_q,
    output logic [DVS_W-1:0] o_rem
);

    logic [DVS_W+1:0] w_t;
    logic [DVS_W+1:0] w_d1;
    logic [DVS_W+1:0] w_d2;
    logic [DVS_W+1:0] w_d3;
    logic [DVS_W-1:0] w_sub;

    // The difference always fits in 8 bits, so only the low bytes need subtracting.
    always_comb begin
        w_t  = {i_rem, i_pair};
        w_d1 = {2'b00, i_dvs};
        w_d2 = {1'b0, i_dvs, 1'b0};
        w_d3 = w_d1 + w_d2;
        if (w_t >= w_d3) begin
            o_q   = 2'd3;
            w_sub = w_d3[DVS_W-1:0];
        end else if (w_t >= w_d2) begin
            o_q   = 2'd2;
            w_sub = w_d2[DVS_W-1:0];
        end else if (w_t >= w_d1) begin
            o_q   = 2'd1;
            w_sub = i_dvs;
        end else begin
            o_q   = 2'd0;
            w_sub = '0;
        end
        o_rem = w_t[DVS_W-1:0] - w_sub;
    end

endmodule
`default_nettype wire

// File: rtl/radix4_div_pipe.sv
`default_nettype none
// ============================================================================
// Module      : radix4_div_pipe
// Description : 16/8 unsigned radix-4 restoring divider, 4-cycle pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module radix4_div_pipe
    import radix4_div_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [DVD_W-1:0] dvd_i,
    input  logic [DVS_W-1:0] dvs_i,
    output logic             valid_o,
    output logic [QUO_W-1:0] quo_o,
    output logic [DVS_W-1:0] rem_o,
    output logic             dz_o,
    output logic             ovf_o
);

    stage_t           src   [STAGES];
    stage_t           stg_d [STAGES];
    stage_t           stg_q [STAGES-1];
    logic [1:0]       w_q   [STAGES];
    logic [DVS_W-1:0] w_rem [STAGES];

    logic             w_dz;
    logic             valid_d, valid_q;
    logic [QUO_W-1:0] quo_d, quo_q;
    logic [DVS_W-1:0] rem_d, rem_q;
    logic             dz_d, dz_q;
    logic             ovf_d, ovf_q;

    assign w_dz = (dvs_i == '0);

    always_comb begin
        src[0] = '{valid:  valid_i,
                   rem:    dvd_i[DVD_W-1:DVS_W],
                   dvd_lo: dvd_i[DVD_W-DVS_W-1:0],
                   dvs:    dvs_i,
                   quo:    '0,
                   dz:     w_dz,
                   ovf:    !w_dz && (dvd_i[DVD_W-1:DVS_W] >= dvs_i)};
        for (int k = 1; k < STAGES; k++) begin
            src[k] = stg_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        radix4_div_stage u_stage (
            .i_rem  (src[g].rem),
            .i_pair (src[g].dvd_lo[DVD_W-DVS_W-1-2*g -: 2]),
            .i_dvs  (src[g].dvs),
            .o_q    (w_q[g]),
            .o_rem  (w_rem[g])
        );
    end

    // Stage k fills quotient bits [7-2k : 6-2k], most significant pair first.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stg_d[k]     = src[k];
            stg_d[k].rem = w_rem[k];
            stg_d[k].quo[QUO_W-1-2*k -: 2] = w_q[k];
        end
    end

    always_comb begin
        valid_d = stg_d[STAGES-1].valid;
        dz_d    = stg_d[STAGES-1].dz;
        ovf_d   = stg_d[STAGES-1].ovf;
        quo_d   = stg_d[STAGES-1].quo;
        rem_d   = stg_d[STAGES-1].rem;
        if (stg_d[STAGES-1].dz) begin
            quo_d = '1;
            rem_d = stg_d[STAGES-1].dvd_lo;
        end else if (stg_d[STAGES-1].ovf) begin
            quo_d = '1;
            rem_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES-1; k++) begin
                stg_q[k] <= '0;
            end
            valid_q <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES-1; k++) begin
                stg_q[k] <= stg_d[k];
            end
            valid_q <= valid_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign quo_o   = quo_q;
    assign rem_o   = rem_q;
    assign dz_o    = dz_q;
    assign ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_radix4_div_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_radix4_div_pipe
// Description : Self-checking bench: directed table, random stream, reset flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radix4_div_pipe;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [15:0] dvd_i;
    logic [7:0]  dvs_i;
    logic        valid_o;
    logic [7:0]  quo_o;
    logic [7:0]  rem_o;
    logic        dz_o;
    logic        ovf_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    radix4_div_pipe dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .dvd_i   (dvd_i),
        .dvs_i   (dvs_i),
        .valid_o (valid_o),
        .quo_o   (quo_o),
        .rem_o   (rem_o),
        .dz_o    (dz_o),
        .ovf_o   (ovf_o)
    );

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  quo;
        logic [7:0]  rem;
        logic        dz;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  quo;
        logic [7:0]  rem;
        logic        dz;
        logic        ovf;
    } exp_t;

    vec_t vecs [6];
    exp_t sb [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Plain integer division; overflow is simply a quotient above 255.
    function automatic exp_t model(input logic v, input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t e;
        int unsigned q;
        e.valid = v;
        e.dvd   = dvd;
        e.dvs   = dvs;
        e.dz    = 1'b0;
        e.ovf   = 1'b0;
        if (dvs == 0) begin
            e.dz  = 1'b1;
            e.quo = 8'hFF;
            e.rem = dvd[7:0];
        end else begin
            q = int'(dvd) / int'(dvs);
            if (q > 255) begin
                e.ovf = 1'b1;
                e.quo = 8'hFF;
                e.rem = 8'h00;
            end else begin
                e.quo = 8'(q);
                e.rem = 8'(int'(dvd) % int'(dvs));
            end
        end
        return e;
    endfunction

    // Scoreboard: every edge's sampled operands are due four edges later.
    initial begin
        logic s_rst;
        exp_t e;
        exp_t x;
        forever begin
            @(posedge clk);
            s_rst = rst_i;
            e = model(valid_i, dvd_i, dvs_i);
            #1;
            if (s_rst) begin
                sb.delete();
                chk("rst_valid", 32'(valid_o), 0);
                chk("rst_quo", 32'(quo_o), 0);
                chk("rst_rem", 32'(rem_o), 0);
                chk("rst_dz", 32'(dz_o), 0);
                chk("rst_ovf", 32'(ovf_o), 0);
            end else begin
                sb.push_back(e);
                if (sb.size() < 4) begin
                    chk("flush_valid", 32'(valid_o), 0);
                end else begin
                    x = sb.pop_front();
                    chk("sb_valid", 32'(valid_o), 32'(x.valid));
                    if (x.valid) begin
                        chk("sb_quo", 32'(quo_o), 32'(x.quo));
                        chk("sb_rem", 32'(rem_o), 32'(x.rem));
                        chk("sb_dz", 32'(dz_o), 32'(x.dz));
                        chk("sb_ovf", 32'(ovf_o), 32'(x.ovf));
                        if (!x.dz && !x.ovf) begin
                            chk("invariant",
                                32'((int'(quo_o) * int'(x.dvs) + int'(rem_o) == int'(x.dvd))
                                    && (rem_o < x.dvs)), 1);
                        end
                    end
                end
            end
        end
    end

    task automatic drive_rand(input bit allow_exc);
        int unsigned d;
        valid_i = 1'b1;
        if (allow_exc && $urandom_range(0, 49) == 0) begin
            dvs_i = 8'($urandom_range(0, 255));
            dvd_i = 16'($urandom);
        end else begin
            d     = $urandom_range(1, 255);
            dvs_i = 8'(d);
            dvd_i = 16'($urandom_range(0, d * 256 - 1));
        end
    endtask

    task automatic check_table(input vec_t v);
        chk("tbl_valid", 32'(valid_o), 1);
        chk("tbl_quo", 32'(quo_o), 32'(v.quo));
        chk("tbl_rem", 32'(rem_o), 32'(v.rem));
        chk("tbl_dz", 32'(dz_o), 32'(v.dz));
        chk("tbl_ovf", 32'(ovf_o), 32'(v.ovf));
    endtask

    initial begin
        vecs[0] = '{16'h3039, 8'd100, 8'h7B, 8'h2D, 1'b0, 1'b0};
        vecs[1] = '{16'hC350, 8'd250, 8'd200, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{16'h0012, 8'd0,   8'hFF, 8'h12, 1'b1, 1'b0};
        vecs[3] = '{16'h6400, 8'd100, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{16'h63FF, 8'd100, 8'hFF, 8'h63, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 8'd1,   8'h00, 8'h00, 1'b0, 1'b0};

        rst_i   = 1'b1;
        valid_i = 1'b0;
        dvd_i   = '0;
        dvs_i   = '0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;

        // Directed vectors, each isolated so the 4-cycle latency is pinned down.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid_i = 1'b1;
            dvd_i   = vecs[i].dvd;
            dvs_i   = vecs[i].dvs;
            @(negedge clk);
            valid_i = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check_table(vecs[i]);
        end

        // Six back-to-back, one bubble, two more.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_rand(1'b0);
        end
        @(negedge clk);
        valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_rand(1'b0);
        end
        @(negedge clk);
        valid_i = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) valid_i = 1'b0;
            else drive_rand(1'b1);
        end

        // Reset with three ops in flight and valid_i held high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_rand(1'b0);
        end
        @(negedge clk);
        rst_i = 1'b1;
        drive_rand(1'b0);
        @(negedge clk);
        rst_i   = 1'b0;
        valid_i = 1'b1;
        dvd_i   = vecs[0].dvd;
        dvs_i   = vecs[0].dvs;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_table(vecs[0]);

        repeat (6) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/radix4_div_pipe.md
# radix4_div_pipe

Pipelined unsigned radix-4 restoring divider: 16-bit dividend by 8-bit divisor, giving an 8-bit quotient and an 8-bit remainder. It is the inverse datapath of the team's 8x8 radix-4 multiplier. A multiplier product can be fed straight in to recover one operand. Four digit stages retire 2 quotient bits each, accepting one operation per cycle with fixed 4-cycle latency and no backpressure.

## Interface
- Parameters: none. Widths are fixed by the package.
- Ports:
  - clk_i  in  1  clock; all state updates on the rising edge.
  - rst_i  in  1  reset; synchronous, active-high.
  - valid_i  in  1  operands valid this cycle.
  - dvd_i  in  16  dividend.
  - dvs_i  in  8  divisor.
  - valid_o  out  1  result valid.
  - quo_o  out  8  quotient.
  - rem_o  out  8  remainder.
  - dz_o  out  1  divide-by-zero.
  - ovf_o  out  1  quotient overflow, meaning it does not fit in 8 bits.

## Operation
- Pre-check, combinational on the inputs:
  - dz = (dvs_i == 0).
  - ovf = !dz && (dvd_i[15:8] >= dvs_i).
  - Exception = dz | ovf.
- Initial partial remainder R0 = dvd_i[15:8]. R < D is guaranteed when there is no exception.
- Stage k (k = 1..4) consumes dividend bit pair P = dvd[9-2k : 8-2k]:
  - T = {R, P}, 10 bits.
  - Compare T against D, 2D and 3D, each zero-extended to 10 bits.
  - Digit q = number of those multiples that are <= T, in the range 0..3.
  - R' = (T - q*D)[7:0].
  - Quotient bits [9-2k : 8-2k] = q.
- Each stage register carries:
  - valid
  - R
  - the remaining dividend bits
  - D
  - the quotient bits accumulated so far
  - dz and ovf
- On exception, stages still run but the output is forced:
  - dz: quo_o = 8'hFF, rem_o = dvd[7:0], dz_o = 1, ovf_o = 0.
  - ovf: quo_o = 8'hFF, rem_o = 8'h00, dz_o = 0, ovf_o = 1.
- valid_i = 0 inserts a bubble: stage valid clears and data registers may hold. Outputs when valid_o = 0 are don't-care except after reset.
- Invariant for non-exception results: quo*dvs + rem == dvd, and rem < dvs.

## Timing
- Operands are sampled at edge E with valid_i = 1. valid_o, quo_o, rem_o, dz_o and ovf_o are registered and valid after edge E+3, i.e. the result appears 4 cycles after the input.
- Throughput is 1 op/cycle. Results come out in order, one per accepted input, with bubbles preserved.
- Reset, when rst_i is high at an edge:
  - All stage valid bits clear, and all data registers go to 0.
  - Outputs become valid_o = 0, quo_o = 0, rem_o = 0, dz_o = 0, ovf_o = 0.
- Reset mid-operation:
  - In-flight ops are discarded and never appear.
  - valid_i is ignored during any cycle where rst_i = 1.
  - An op presented in the first cycle after rst_i falls is accepted normally.
- No combinational path from inputs to outputs.

## Structure
- Package radix4_div_pkg holds:
  - constants DVD_W = 16, DVS_W = 8, QUO_W = 8, STAGES = 4;
  - a typedef for the stage register struct (valid, rem, dvd_lo, dvs, quo, dz, ovf).
- Sub-module radix4_div_stage is combinational, instantiated 4 times:
  - inputs: R (8), P (2), D (8);
  - outputs: q (2) and R' (8).
- The top level holds the pre-check, the 4 stage registers and the output forcing.

## Test plan
- Basic divide: dvd 16'h3039 (12345), dvs 100. Expect quo 8'h7B (123), rem 8'h2D (45), flags 0, valid_o 4 cycles later.
- Multiplier round-trip: dvd 16'hC350 (50000), dvs 250. Expect quo 200, rem 0.
- Divide-by-zero: dvd 16'h0012, dvs 0. Expect dz_o = 1, ovf_o = 0, quo 8'hFF, rem 8'h12.
- Overflow: dvd 16'h6400, dvs 100. Expect ovf_o = 1, quo 8'hFF, rem 0. Also dvd 16'h63FF, dvs 100: no overflow, quo 8'hFF, rem 8'h63.
- Streaming: 6 back-to-back random ops, then a 1-cycle bubble, then 2 more ops. Expect outputs on consecutive cycles in input order with the bubble reproduced. A reference model checks quo*dvs + rem == dvd for 10k random non-exception ops.
- Reset mid-flight: 3 ops in flight, then rst_i high for 1 cycle while valid_i = 1. Expect valid_o = 0 for the next 4 cycles. An op issued the cycle after reset emerges exactly 4 cycles later with the correct result.
